sweep_stim_checker: RTL and testbench



---
 rtl/sweep_stim_checker.sv | 91 +++++++++
 tb/tb_sweep_stim_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_stim_checker.sv
// Exhaustive stimulus sweep over 0..2^IN_W-1, each pattern held HOLD cycles, UUT response folded into a Galois MISR.
// Latency: stim=0 one cycle after start; each response is sampled on the last dwell edge; sample_valid follows one cycle later.
// Backpressure: none; start is ignored while busy, and a sweep runs to completion unless reset.
module sweep_stim_checker #(
    parameter int                IN_W  = 2,
    parameter int                OUT_W = 2,
    parameter int                HOLD  = 4,
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [IN_W-1:0]  sample_pat,
    output logic [SIG_W-1:0] signature
);

    // Dwell counter needs at least one bit even when every edge is a sample edge.
    localparam int             DW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DW-1:0]  LAST = DW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DW-1:0]     dwell;
    logic [SIG_W-1:0]  misr_next;

    // Next signature: shift, conditional polynomial feedback, zero-extended response folded in.
    always_comb begin
        misr_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp);
    end

    // Sweep controller: stepping, sampling and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            stim         <= '0;
            dwell        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            sample_pat   <= '0;
            signature    <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        stim      <= '0;
                        dwell     <= '0;
                        signature <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (dwell != LAST) begin
                        dwell <= dwell + 1'b1;
                    end else begin
                        signature    <= misr_next;
                        sample_valid <= 1'b1;
                        sample_pat   <= stim;
                        dwell        <= '0;
                        if (&stim) begin
                            // Sweep ends on all-ones; stim stays there so it never wraps.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            stim <= stim + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_stim_checker.sv
// Bench for sweep_stim_checker: three instances (HOLD=1, 4, 3) with IN_W=OUT_W=2, SIG_W=16.
// Responses come from loopback, inverted loopback, random lookup tables and glitching responders.
// The reference computes the expected waveform from pattern index and dwell arithmetic.
module tb_sweep_stim_checker;

    localparam int NDUT = 3;
    localparam int NPAT = 4;

    logic        clk;
    logic        rst_s   [NDUT];
    logic        start_s [NDUT];
    logic [1:0]  resp_s  [NDUT];
    logic [1:0]  o_stim  [NDUT];
    logic        o_busy  [NDUT];
    logic        o_done  [NDUT];
    logic        o_sv    [NDUT];
    logic [1:0]  o_spat  [NDUT];
    logic [15:0] o_sig   [NDUT];

    int vectors;
    int miscompares;
    logic [1:0] tbl [NPAT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sweep_stim_checker #(
            .IN_W (2),
            .OUT_W(2),
            .HOLD ((g == 0) ? 1 : (g == 1) ? 4 : 3),
            .SIG_W(16),
            .POLY (16'h1021)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_s[g]),
            .start       (start_s[g]),
            .stim        (o_stim[g]),
            .resp        (resp_s[g]),
            .busy        (o_busy[g]),
            .done        (o_done[g]),
            .sample_valid(o_sv[g]),
            .sample_pat  (o_spat[g]),
            .signature   (o_sig[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 4 : 3;
    endfunction

    // Galois MISR step: polynomial division of the response stream by x^16+x^12+x^5+1.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
        logic [16:0] wide;
        wide = {s, 1'b0};
        if (wide[16]) wide = wide ^ 17'h11021;
        return wide[15:0] ^ {14'd0, r};
    endfunction

    task automatic new_table();
        for (int i = 0; i < NPAT; i++) tbl[i] = 2'($urandom_range(0, 3));
    endtask

    // Full sweep on instance g.  mode: 0 loopback, 1 inverted, 2 table, 3 loopback with all-ones glitches off the sample cycle.
    task automatic sweep(input int g, input int mode, input bit pre_started, input bit keep_start,
                         input int mid_start, input int exp_final, output logic [15:0] final_sig);
        int h;
        int total;
        int k;
        logic [15:0] sig;
        logic [1:0]  exp_stim;
        logic [1:0]  r;
        bit          exp_sv;
        h     = hold_of(g);
        total = NPAT * h;
        sig   = 16'h0;
        if (!pre_started) start_s[g] = 1'b1;
        @(posedge clk); #1;
        start_s[g] = keep_start;
        for (int j = 0; j <= total; j++) begin
            exp_stim = (j < total) ? 2'(j / h) : 2'd3;
            exp_sv   = (j > 0) && (j % h == 0);
            vectors++;
            if (o_stim[g] !== exp_stim) begin
                miscompares++;
                $display("FAIL stim dut%0d step%0d got %0d want %0d", g, j, o_stim[g], exp_stim);
            end
            vectors++;
            if (o_busy[g] !== (j < total)) begin
                miscompares++;
                $display("FAIL busy dut%0d step%0d got %0b want %0b", g, j, o_busy[g], (j < total));
            end
            vectors++;
            if (o_done[g] !== (j == total)) begin
                miscompares++;
                $display("FAIL done dut%0d step%0d got %0b want %0b", g, j, o_done[g], (j == total));
            end
            vectors++;
            if (o_sv[g] !== exp_sv) begin
                miscompares++;
                $display("FAIL sample_valid dut%0d step%0d got %0b want %0b", g, j, o_sv[g], exp_sv);
            end
            if (exp_sv) begin
                k = j / h - 1;
                vectors++;
                if (o_spat[g] !== 2'(k)) begin
                    miscompares++;
                    $display("FAIL sample_pat dut%0d step%0d got %0d want %0d", g, j, o_spat[g], k);
                end
            end
            vectors++;
            if (o_sig[g] !== sig) begin
                miscompares++;
                $display("FAIL signature dut%0d step%0d got %h want %h", g, j, o_sig[g], sig);
            end
            if (j < total) begin
                case (mode)
                    0:       r = exp_stim;
                    1:       r = ~exp_stim;
                    2:       r = tbl[exp_stim];
                    default: r = (j % h == h - 1) ? exp_stim : 2'b11;
                endcase
                resp_s[g] = r;
                if (j % h == h - 1) sig = misr_step(sig, r);
                start_s[g] = (j == mid_start) ? 1'b1 : keep_start;
                @(posedge clk); #1;
            end
        end
        if (exp_final >= 0) begin
            vectors++;
            if (o_sig[g] !== 16'(exp_final)) begin
                miscompares++;
                $display("FAIL final_signature dut%0d got %h want %h", g, o_sig[g], 16'(exp_final));
            end
        end
        final_sig = sig;
    endtask

    task automatic check_frozen(input int g, input logic [15:0] sig, input int cycles);
        start_s[g] = 1'b0;
        resp_s[g]  = 2'($urandom_range(0, 3));
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            resp_s[g] = 2'($urandom_range(0, 3));
            vectors++;
            if (o_done[g] !== 1'b1 || o_busy[g] !== 1'b0 || o_sv[g] !== 1'b0 || o_stim[g] !== 2'd3 || o_sig[g] !== sig) begin
                miscompares++;
                $display("FAIL frozen dut%0d cyc%0d done=%0b busy=%0b sv=%0b stim=%0d sig=%h want 1/0/0/3/%h",
                         g, i, o_done[g], o_busy[g], o_sv[g], o_stim[g], o_sig[g], sig);
            end
        end
    endtask

    task automatic check_zero(input int g, input string tag);
        vectors++;
        if (o_stim[g] !== 2'd0 || o_busy[g] !== 1'b0 || o_done[g] !== 1'b0 || o_sv[g] !== 1'b0 ||
            o_spat[g] !== 2'd0 || o_sig[g] !== 16'h0) begin
            miscompares++;
            $display("FAIL %s dut%0d stim=%0d busy=%0b done=%0b sv=%0b pat=%0d sig=%h want all zero",
                     tag, g, o_stim[g], o_busy[g], o_done[g], o_sv[g], o_spat[g], o_sig[g]);
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < NDUT; g++) begin
            rst_s[g] = 1'b0; start_s[g] = 1'b0; resp_s[g] = 2'b11;
        end
        #3;
        for (int g = 0; g < NDUT; g++) check_zero(g, "reset_async");
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) rst_s[g] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) check_zero(g, "idle_no_start");
    endtask

    task automatic test_loopback();
        logic [15:0] s;
        sweep(0, 0, 1'b0, 1'b0, -1, 16'h0003, s);
        check_frozen(0, s, 4);
    endtask

    task automatic test_inverted();
        logic [15:0] s;
        sweep(0, 1, 1'b0, 1'b0, -1, 16'h0012, s);
    endtask

    task automatic test_dwell();
        logic [15:0] s;
        sweep(1, 0, 1'b0, 1'b0, -1, 16'h0003, s);
        check_frozen(1, s, 3);
    endtask

    task automatic test_glitch();
        logic [15:0] s;
        sweep(2, 3, 1'b0, 1'b0, -1, 16'h0003, s);
    endtask

    task automatic test_start_during_run();
        logic [15:0] s;
        sweep(1, 0, 1'b0, 1'b0, 6, 16'h0003, s);
        sweep(2, 1, 1'b0, 1'b0, 4, 16'h0012, s);
    endtask

    task automatic test_restart_from_done();
        logic [15:0] s1;
        logic [15:0] s2;
        new_table();
        sweep(1, 2, 1'b0, 1'b0, -1, -1, s1);
        check_frozen(1, s1, 2);
        sweep(1, 2, 1'b0, 1'b0, -1, -1, s2);
        vectors++;
        if (o_sig[1] !== s1) begin
            miscompares++;
            $display("FAIL restart_repeat got %h want %h", o_sig[1], s1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        new_table();
        sweep(0, 2, 1'b0, 1'b1, -1, -1, s);
        sweep(0, 2, 1'b1, 1'b0, -1, -1, s);
        sweep(2, 0, 1'b0, 1'b1, -1, 16'h0003, s);
        sweep(2, 0, 1'b1, 1'b0, -1, 16'h0003, s);
    endtask

    task automatic test_random();
        logic [15:0] s;
        int g;
        for (int n = 0; n < 8; n++) begin
            g = $urandom_range(0, NDUT - 1);
            new_table();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            sweep(g, $urandom_range(0, 1) ? 2 : 3, 1'b0, 1'b0, $urandom_range(0, 2) == 0 ? $urandom_range(0, 10) : -1, -1, s);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s;
        start_s[1] = 1'b1;
        resp_s[1]  = 2'b01;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        vectors++;
        if (o_stim[1] !== 2'd2 || o_busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_pattern got stim=%0d busy=%0b want 2/1", o_stim[1], o_busy[1]);
        end
        #2 rst_s[1] = 1'b0;
        #1 check_zero(1, "reset_mid_run");
        repeat (2) @(posedge clk);
        #1;
        rst_s[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_zero(1, "no_resume");
        // Reset release and start in the same cycle: start counts at the following edge.
        rst_s[1] = 1'b0;
        #2;
        rst_s[1]   = 1'b1;
        start_s[1] = 1'b1;
        sweep(1, 0, 1'b1, 1'b0, -1, 16'h0003, s);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_loopback();
        test_inverted();
        test_dwell();
        test_glitch();
        test_start_during_run();
        test_restart_from_done();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
